// File: rtl/lc3b_types.sv
// Shared LC-3b cache types.
// Geometry: 2 ways, 8 sets, 128-bit lines.
package lc3b_types;

    typedef logic [2:0] lc3b_index;
    typedef logic       lc3b_way;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

endpackage

// File: rtl/cache_control.sv
// Write-back 2-way cache controller.
// Hit/miss decision, victim write-back and line fill.
module cache_control
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic mem_read,
    input  logic mem_write,
    input  logic hit0,
    input  logic hit1,
    input  logic dirty0,
    input  logic dirty1,
    input  logic lru_out,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic way_sel,
    output logic load_data,
    output logic data_src,
    output logic load_tag,
    output logic load_valid,
    output logic set_dirty,
    output logic clear_dirty,
    output logic load_lru,
    output logic lru_in,
    output logic pmem_addr_sel
);

    cache_state_t r_state;
    cache_state_t w_next;
    lc3b_way      r_victim;
    logic         w_req;
    logic         w_hit;
    lc3b_way      w_hit_way;
    logic         w_victim_dirty;

    assign w_req          = mem_read | mem_write;
    assign w_hit          = hit0 | hit1;
    // Way 0 wins if both ways claim a hit.
    assign w_hit_way      = hit0 ? 1'b0 : 1'b1;
    assign w_victim_dirty = lru_out ? dirty1 : dirty0;

    // State register; victim is latched only on miss detection in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_victim <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req && !w_hit) begin
                r_victim <= lru_out;
            end
        end
    end

    // Next-state and output decode; everything is held low during reset.
    always_comb begin
        w_next        = r_state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        data_src      = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        set_dirty     = 1'b0;
        clear_dirty   = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        pmem_addr_sel = 1'b0;
        if (!reset) begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            mem_resp = 1'b1;
                            way_sel  = w_hit_way;
                            load_lru = 1'b1;
                            lru_in   = ~w_hit_way;
                            if (mem_write) begin
                                load_data = 1'b1;
                                set_dirty = 1'b1;
                            end
                        end else if (w_victim_dirty) begin
                            w_next = WRITEBACK;
                        end else begin
                            w_next = ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    way_sel       = r_victim;
                    if (pmem_resp) begin
                        // A dropped request skips the fill.
                        w_next = w_req ? ALLOCATE : IDLE;
                    end
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    way_sel   = r_victim;
                    if (pmem_resp) begin
                        load_data   = 1'b1;
                        data_src    = 1'b1;
                        load_tag    = 1'b1;
                        load_valid  = 1'b1;
                        clear_dirty = 1'b1;
                        w_next      = IDLE;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_control.md
# cache_control

Write-back, 2-way set-associative cache controller for the LC-3b memory hierarchy. It sequences the cache datapath (per-way 8-entry × 128-bit data arrays plus tag/valid/dirty/LRU arrays indexed by lc3b_index) between CPU requests and physical memory. It decides hit or miss, selects the victim, performs write-back and line fill, and updates tag, valid, dirty and LRU state.

## Interface
Parameters:
- None. Geometry is fixed by lc3b_types: 2 ways, 8 sets, 128-bit lines.

Ports (all 1 bit):
- clk  in  — rising-edge clock.
- reset  in  — synchronous, active-high.
- mem_read / mem_write  in  — CPU request. Held stable until mem_resp. Never asserted together; if they are, the request is treated as a write.
- hit0 / hit1  in  — way 0/1 valid and tag match for the current index (combinational from datapath).
- dirty0 / dirty1  in  — dirty bit of way 0/1 at the current index.
- lru_out  in  — LRU way at the current index; this way is the replacement victim.
- pmem_resp  in  — physical memory done; 1-cycle pulse.
- mem_resp  out  — CPU request complete.
- pmem_read / pmem_write  out  — physical memory request, held until pmem_resp.
- way_sel  out  — way addressed by all array loads and by the read mux.
- load_data  out  — write data array of way_sel.
- data_src  out  — 0 = CPU byte-merged line, 1 = pmem line.
- load_tag / load_valid  out  — write tag and set valid in way_sel.
- set_dirty / clear_dirty  out  — dirty bit control for way_sel.
- load_lru / lru_in  out  — write LRU for the current index with lru_in.
- pmem_addr_sel  out  — 0 = {CPU tag, index}, 1 = {victim tag, index}.

## Operation
States: IDLE, WRITEBACK, ALLOCATE.

IDLE, no request:
- All outputs 0.

IDLE, read hit (hitN=1):
- mem_resp=1, way_sel=N.
- load_lru=1, lru_in=~N.

IDLE, write hit (hitN=1):
- Same outputs as read hit, plus load_data=1, data_src=0, set_dirty=1.

IDLE, miss (hit0=hit1=0):
- Capture victim = lru_out in a register.
- Next state is WRITEBACK if the victim's dirty bit is set, else ALLOCATE.
- No mem_resp. No array writes.

WRITEBACK:
- pmem_write=1, pmem_addr_sel=1, way_sel=victim.
- On pmem_resp → ALLOCATE.

ALLOCATE:
- pmem_read=1, pmem_addr_sel=0, way_sel=victim.
- On pmem_resp, in the same cycle: load_data=1, data_src=1, load_tag=1, load_valid=1, clear_dirty=1. Next state IDLE.
- Back in IDLE the request is re-evaluated and now hits. That hit completes it, including the write merge and the LRU update.

Rules:
- hit0 and hit1 both 1 is illegal; way 0 wins.
- LRU is updated only on hits, never during WRITEBACK or ALLOCATE.
- The victim register is frozen from miss detection until return to IDLE.
- pmem_read and pmem_write are never both 1.
- CPU request dropped mid-miss: the current pmem transaction completes, then the FSM returns to IDLE without mem_resp.

## Timing
Reset:
- While reset=1, all outputs are forced to 0.
- The state register loads IDLE on the edge.
- Reset during WRITEBACK or ALLOCATE: pmem_read/pmem_write drop in the cycle after that edge. A pmem_resp arriving afterwards is ignored.

Output decode:
- IDLE outputs are Mealy, decoded from the request and hit inputs.
- WRITEBACK/ALLOCATE pmem_* outputs are Moore.
- ALLOCATE load strobes are Mealy on pmem_resp.

Latency:
- Hit: mem_resp in the same cycle as the request.
- Clean miss: 1 (detect) + N (ALLOCATE, N = pmem latency incl. resp cycle) + 1 (hit).
- Dirty miss: 1 + Nw + Nr + 1.

Array writes land on the clk edge following the strobe.

## Structure
- lc3b_types gains cache_state_t {IDLE, WRITEBACK, ALLOCATE}.
- Way index is 1-bit; lc3b_index stays 3-bit.
- Single module: state register, victim register, and combinational next-state/output decode.
- No sub-module. The sibling cache_datapath owns the arrays. The top-level cache wires cache_control to cache_datapath.

## Test plan
- Cold read, all invalid, index 3, pmem latency 4: pmem_read high 4 cycles, fill strobes with pmem_resp, mem_resp 1 cycle later. LRU[3] then = 1 (way 0 filled).
- Read hit way 1: mem_resp in the request cycle, lru_in=0, load_lru=1. No pmem activity.
- Write miss with dirty victim (lru_out=1, dirty1=1): WRITEBACK with pmem_addr_sel=1, way_sel=1, then ALLOCATE. Final hit asserts load_data, data_src=0, set_dirty.
- Write hit way 0: single cycle with load_data, set_dirty, mem_resp, lru_in=1.
- Reset asserted in ALLOCATE cycle 2: the next cycle is IDLE with all outputs 0. A later pmem_resp causes no array loads.
- Back-to-back misses to the same set: the second victim is the way the first fill did not use.
